// File: rtl/ins_fetcher_pkg.sv
// Shared fetch-stage types and constants for ins_fetcher and its instruction cache.
package ins_fetcher_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned ADDR_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/icache_dm.sv
// Direct-mapped single-word-per-line instruction cache: combinational lookup, synchronous fill.
// Instantiated by ins_fetcher only when IFETCH_ICACHE_EN is defined.
module icache_dm
  import ins_fetcher_pkg::*;
#(
  parameter int unsigned IDX_BIT = 6
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [31:2]       lookup_addr,
  output logic              hit,
  output logic [INST_W-1:0] hit_data,
  input  logic              fill_en,
  input  logic [31:2]       fill_addr,
  input  logic [INST_W-1:0] fill_data
);

  localparam int unsigned Lines = 1 << IDX_BIT;
  localparam int unsigned TagW  = 30 - IDX_BIT;

  logic [Lines-1:0]  valid_q;
  logic [TagW-1:0]   tag_q  [Lines];
  logic [INST_W-1:0] data_q [Lines];

  logic [IDX_BIT-1:0] lookup_idx, fill_idx;
  logic [TagW-1:0]    lookup_tag, fill_tag;

  assign lookup_idx = lookup_addr[IDX_BIT+1:2];
  assign lookup_tag = lookup_addr[31:IDX_BIT+2];
  assign fill_idx   = fill_addr[IDX_BIT+1:2];
  assign fill_tag   = fill_addr[31:IDX_BIT+2];

  assign hit      = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
  assign hit_data = data_q[lookup_idx];

  // Only valid bits are reset; tag/data arrays are plain storage.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= fill_data;
    end
  end

endmodule

// File: rtl/ins_fetcher.sv
// Instruction fetch stage: PC, memory request handshake, decoder hand-off and ROB redirect.
// Define IFETCH_ICACHE_EN to add a direct-mapped instruction cache (icache_dm).
module ins_fetcher
  import ins_fetcher_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
`ifdef IFETCH_ICACHE_EN
  , parameter int unsigned ICACHE_IDX_BIT = 6
`endif
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_done,
  input  logic [INST_W-1:0] mem_data,
  output logic              inst_input,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              dec_stall,
  input  logic [ADDR_W-1:0] dec_next_pc,
  input  logic              rob_clear,
  input  logic [ADDR_W-1:0] rob_new_pc
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inst_input_q, inst_input_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] inst_addr_q, inst_addr_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

  logic              hit;
  logic [INST_W-1:0] hit_data;
  logic              fill_en;

`ifdef IFETCH_ICACHE_EN
  // Fill uses the latched request address so drained responses still land on the right line.
  icache_dm #(
    .IDX_BIT (ICACHE_IDX_BIT)
  ) u_icache (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .lookup_addr (pc_q[31:2]),
    .hit         (hit),
    .hit_data    (hit_data),
    .fill_en     (fill_en),
    .fill_addr   (mem_addr_q[31:2]),
    .fill_data   (mem_data)
  );
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_input_d = inst_input_q;
    inst_d       = inst_q;
    inst_addr_d  = inst_addr_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    fill_en      = 1'b0;

    if (rdy_in) begin
      unique case (state_q)
        S_REQ: begin
          if (rob_clear) begin
            pc_d         = rob_new_pc & WORD_ALIGN_MASK;
            inst_input_d = 1'b0;
          end else if (hit) begin
            inst_d       = hit_data;
            inst_addr_d  = pc_q;
            inst_input_d = 1'b1;
            state_d      = S_HOLD;
          end else begin
            mem_req_d  = 1'b1;
            mem_addr_d = pc_q;
            state_d    = S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_done) begin
            mem_req_d = 1'b0;
            fill_en   = 1'b1;
          end
          if (rob_clear) begin
            pc_d         = rob_new_pc & WORD_ALIGN_MASK;
            inst_input_d = 1'b0;
            state_d      = mem_done ? S_REQ : S_DRAIN;
          end else if (mem_done) begin
            inst_d       = mem_data;
            inst_addr_d  = pc_q;
            inst_input_d = 1'b1;
            state_d      = S_HOLD;
          end
        end
        S_HOLD: begin
          if (rob_clear) begin
            pc_d         = rob_new_pc & WORD_ALIGN_MASK;
            inst_input_d = 1'b0;
            state_d      = S_REQ;
          end else if (inst_input_q && !dec_stall) begin
            pc_d         = dec_next_pc & WORD_ALIGN_MASK;
            inst_input_d = 1'b0;
            state_d      = S_REQ;
          end
        end
        S_DRAIN: begin
          if (rob_clear) begin
            pc_d = rob_new_pc & WORD_ALIGN_MASK;
          end
          if (mem_done) begin
            mem_req_d = 1'b0;
            fill_en   = 1'b1;
            state_d   = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      inst_input_q <= 1'b0;
      inst_q       <= '0;
      inst_addr_q  <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_input_q <= inst_input_d;
      inst_q       <= inst_d;
      inst_addr_q  <= inst_addr_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign inst_input = inst_input_q;
  assign inst       = inst_q;
  assign inst_addr  = inst_addr_q;

endmodule

// File: tb/tb_ins_fetcher.sv
// Directed self-checking bench for ins_fetcher; expectations follow IFETCH_ICACHE_EN if defined.
module tb_ins_fetcher;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_data;
  logic        inst_input;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        dec_stall;
  logic [31:0] dec_next_pc;
  logic        rob_clear;
  logic [31:0] rob_new_pc;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_in = ~clk_in;

  ins_fetcher u_dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_done    (mem_done),
    .mem_data    (mem_data),
    .inst_input  (inst_input),
    .inst        (inst),
    .inst_addr   (inst_addr),
    .dec_stall   (dec_stall),
    .dec_next_pc (dec_next_pc),
    .rob_clear   (rob_clear),
    .rob_new_pc  (rob_new_pc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  // Advance one clock; outputs are observed 1ns after the edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // One-cycle mem_done pulse carrying data.
  task automatic mem_reply(input logic [31:0] data);
    mem_done = 1'b1;
    mem_data = data;
    tick();
    mem_done = 1'b0;
    mem_data = '0;
  endtask

  initial begin
    rst_in      = 1'b1;
    rdy_in      = 1'b1;
    mem_done    = 1'b0;
    mem_data    = '0;
    dec_stall   = 1'b0;
    dec_next_pc = '0;
    rob_clear   = 1'b0;
    rob_new_pc  = '0;

    tick();
    tick();
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_inst_input", {31'd0, inst_input}, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_addr", inst_addr, 32'd0);
    rst_in = 1'b0;

    // Cold fetch of 0x0, reply after 3 cycles, decoder stalls.
    dec_stall = 1'b1;
    tick();
    check("cold_mem_req", {31'd0, mem_req}, 32'd1);
    check("cold_mem_addr", mem_addr, 32'h0);
    tick();
    tick();
    check("cold_wait_mem_req", {31'd0, mem_req}, 32'd1);
    check("cold_wait_inst_input", {31'd0, inst_input}, 32'd0);
    mem_reply(32'h0050_0093);
    check("cold_inst_input", {31'd0, inst_input}, 32'd1);
    check("cold_inst", inst, 32'h0050_0093);
    check("cold_inst_addr", inst_addr, 32'h0);
    check("cold_mem_req_drop", {31'd0, mem_req}, 32'd0);

    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_inst_input", {31'd0, inst_input}, 32'd1);
      check("stall_inst", inst, 32'h0050_0093);
      check("stall_mem_req", {31'd0, mem_req}, 32'd0);
    end

    // Release; low PC bits must be dropped.
    dec_stall   = 1'b0;
    dec_next_pc = 32'h0000_0007;
    tick();
    check("consume_inst_input", {31'd0, inst_input}, 32'd0);
    dec_stall = 1'b1;
    tick();
    check("fetch4_mem_req", {31'd0, mem_req}, 32'd1);
    check("fetch4_mem_addr", mem_addr, 32'h4);
    mem_reply(32'h0040_0113);
    check("fetch4_inst", inst, 32'h0040_0113);
    check("fetch4_inst_addr", inst_addr, 32'h4);

    // Loop back to 0x0.
    dec_stall   = 1'b0;
    dec_next_pc = 32'h0;
    tick();
    dec_stall = 1'b1;
    tick();
`ifdef IFETCH_ICACHE_EN
    check("loop_hit_inst_input", {31'd0, inst_input}, 32'd1);
    check("loop_hit_mem_req", {31'd0, mem_req}, 32'd0);
    check("loop_hit_inst", inst, 32'h0050_0093);
`else
    check("loop_miss_mem_req", {31'd0, mem_req}, 32'd1);
    check("loop_miss_mem_addr", mem_addr, 32'h0);
    mem_reply(32'h0050_0093);
    check("loop_miss_inst", inst, 32'h0050_0093);
`endif
    check("loop_inst_addr", inst_addr, 32'h0);

    // Redirect while waiting on 0x8: drain, drop the word, refetch at 0x100.
    dec_stall   = 1'b0;
    dec_next_pc = 32'h8;
    tick();
    tick();
    check("wait8_mem_addr", mem_addr, 32'h8);
    rob_clear  = 1'b1;
    rob_new_pc = 32'h100;
    tick();
    rob_clear = 1'b0;
    check("drain_mem_req", {31'd0, mem_req}, 32'd1);
    check("drain_mem_addr", mem_addr, 32'h8);
    tick();
    check("drain2_mem_addr", mem_addr, 32'h8);
    check("drain2_inst_input", {31'd0, inst_input}, 32'd0);
    mem_reply(32'hDEAD_BEEF);
    check("drained_mem_req", {31'd0, mem_req}, 32'd0);
    check("drained_inst_input", {31'd0, inst_input}, 32'd0);
    tick();
    check("redirect_mem_req", {31'd0, mem_req}, 32'd1);
    check("redirect_mem_addr", mem_addr, 32'h100);
    check("redirect_inst_input", {31'd0, inst_input}, 32'd0);
    dec_stall = 1'b1;
    mem_reply(32'h1111_1111);
    check("redirect_inst", inst, 32'h1111_1111);
    check("redirect_inst_addr", inst_addr, 32'h100);

    // Clear in HOLD beats a simultaneous consume.
    dec_stall   = 1'b0;
    dec_next_pc = 32'h40;
    rob_clear   = 1'b1;
    rob_new_pc  = 32'h200;
    tick();
    rob_clear = 1'b0;
    check("hold_clear_inst_input", {31'd0, inst_input}, 32'd0);
    tick();
    check("hold_clear_mem_addr", mem_addr, 32'h200);

    // Freeze mid-WAIT; a clear during the freeze must be ignored.
    rdy_in    = 1'b0;
    rob_clear = 1'b1;
    rob_new_pc = 32'h500;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("frz_mem_req", {31'd0, mem_req}, 32'd1);
      check("frz_mem_addr", mem_addr, 32'h200);
      check("frz_inst_input", {31'd0, inst_input}, 32'd0);
    end
    rob_clear = 1'b0;
    rdy_in    = 1'b1;
    dec_stall = 1'b1;
    mem_reply(32'h2222_2222);
    check("unfrz_inst_input", {31'd0, inst_input}, 32'd1);
    check("unfrz_inst", inst, 32'h2222_2222);
    check("unfrz_inst_addr", inst_addr, 32'h200);

    // Clear and mem_done together in WAIT: word dropped, straight to REQ.
    dec_stall   = 1'b0;
    dec_next_pc = 32'h10;
    tick();
    tick();
    check("wait10_mem_addr", mem_addr, 32'h10);
    rob_clear  = 1'b1;
    rob_new_pc = 32'h306;
    mem_reply(32'h3333_3333);
    rob_clear = 1'b0;
    check("clrdone_mem_req", {31'd0, mem_req}, 32'd0);
    check("clrdone_inst_input", {31'd0, inst_input}, 32'd0);
    tick();
    check("clrdone_mem_req2", {31'd0, mem_req}, 32'd1);
    check("clrdone_mem_addr", mem_addr, 32'h304);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
